irq_ack_sequencer: RTL and testbench

Request-side partner of the 27-channel, three-bus combinational priority interrupt controller. The block captures interrupt edges from 27 sources into sticky pending bits and presents them as three 9-bit request buses to the controller. It samples the controller's bus grant and channel code, then runs the CPU request / acknowledge / end-of-interrupt handshake. On acknowledge it clears the serviced pending bit and issues an interrupt vector.

---
 rtl/irq_pkg.sv | 28 ++
 rtl/irq_edge_pending.sv | 36 +++
 rtl/irq_ack_sequencer.sv | 111 +++++++++++
 tb/tb_irq_ack_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt request/acknowledge sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package irq_pkg;

    localparam int NCH  = 9;
    localparam int NBUS = 3;
    localparam int NSRC = NCH * NBUS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK     = 2'd2,
        SERVICE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        BUS_A = 2'd0,
        BUS_B = 2'd1,
        BUS_C = 2'd2
    } bus_t;

    // Flat source index 0..26 of a (bus, channel) pair.
    function automatic logic [4:0] vec_index(input logic [1:0] bus, input logic [3:0] chan);
        return ({3'b000, bus} * 5'd9) + {1'b0, chan};
    endfunction

endpackage

// File: rtl/irq_edge_pending.sv
// Rising-edge capture of the interrupt sources into sticky pending bits.
// Latency: a source edge is visible on pending one cycle after it is sampled.
// Backpressure: none; bits stay set until cleared by index, a new edge beats a clear.
module irq_edge_pending
    import irq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_in,
    input  logic            clr_en,
    input  logic [4:0]      clr_idx,
    output logic [NSRC-1:0] pending
);

    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] clr_mask;
    logic [NSRC-1:0] set_mask;

    // Decode the single-bit clear and the newly rising sources.
    always_comb begin
        clr_mask = clr_en ? (NSRC'(1) << clr_idx) : '0;
        set_mask = irq_in & ~irq_q;
    end

    // Source history and sticky pending; set is OR-ed after clear so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            irq_q   <= irq_in;
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: rtl/irq_ack_sequencer.sv
// Presents pending interrupts to the priority controller and runs the CPU req/ack/eoi handshake.
// Latency: source edge to int_req is 2 cycles; int_ack to vec_valid is 1 cycle.
// Backpressure: one interrupt in flight; new edges accumulate as pending until back in IDLE.
module irq_ack_sequencer
    import irq_pkg::*;
#(
    parameter int               VEC_W    = 8,
    parameter logic [VEC_W-1:0] VEC_BASE = 8'h20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NSRC-1:0]  irq_in,
    input  logic [NSRC-1:0]  irq_mask,
    output logic [NCH-1:0]   req_a,
    output logic [NCH-1:0]   req_b,
    output logic [NCH-1:0]   req_c,
    input  logic             grant_pa,
    input  logic             grant_pb,
    input  logic             grant_pc,
    input  logic [3:0]       grant_chan,
    output logic             int_req,
    input  logic             int_ack,
    input  logic             eoi,
    output logic [VEC_W-1:0] vec,
    output logic             vec_valid,
    output logic             err
);

    state_t          state;
    bus_t            bus_q;
    logic [3:0]      chan_q;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] presented;
    logic            any_grant;
    bus_t            grant_bus;
    logic            clr_en;
    logic [4:0]      lat_idx;

    // The latched bit clears on the same edge that samples the acknowledge.
    assign lat_idx = vec_index(bus_q, chan_q);
    assign clr_en  = (state == REQ) && int_ack;

    irq_edge_pending u_pending (
        .clk     (clk),
        .rst     (rst),
        .irq_in  (irq_in),
        .clr_en  (clr_en),
        .clr_idx (lat_idx),
        .pending (pending)
    );

    // Request buses are combinational so the controller loop closes in one cycle.
    always_comb begin
        presented = pending & ~irq_mask;
        req_a     = presented[NCH-1:0];
        req_b     = presented[2*NCH-1:NCH];
        req_c     = presented[3*NCH-1:2*NCH];
        any_grant = grant_pa | grant_pb | grant_pc;
        grant_bus = grant_pa ? BUS_A : (grant_pb ? BUS_B : BUS_C);
    end

    // Handshake FSM with registered CPU-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus_q     <= BUS_A;
            chan_q    <= '0;
            int_req   <= 1'b0;
            vec       <= '0;
            vec_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            vec_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_grant) begin
                        if (grant_chan > 4'd8) begin
                            err <= 1'b1;
                        end else begin
                            bus_q   <= grant_bus;
                            chan_q  <= grant_chan;
                            int_req <= 1'b1;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        int_req   <= 1'b0;
                        vec       <= VEC_BASE + VEC_W'(lat_idx);
                        vec_valid <= 1'b1;
                        state     <= ACK;
                    end
                end
                ACK: begin
                    state <= SERVICE;
                end
                SERVICE: begin
                    if (eoi) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ack_sequencer.sv
// Bench for irq_ack_sequencer: priority-controller model, reference model and scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_irq_ack_sequencer;

    logic        clk;
    logic        rst;
    logic [26:0] irq_in;
    logic [26:0] irq_mask;
    logic [8:0]  req_a, req_b, req_c;
    logic        grant_pa, grant_pb, grant_pc;
    logic [3:0]  grant_chan;
    logic        int_req;
    logic        int_ack;
    logic        eoi;
    logic [7:0]  vec;
    logic        vec_valid;
    logic        err;
    logic        force_bad;

    int checks = 0;
    int errors = 0;

    irq_ack_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .irq_mask   (irq_mask),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .grant_pa   (grant_pa),
        .grant_pb   (grant_pb),
        .grant_pc   (grant_pc),
        .grant_chan (grant_chan),
        .int_req    (int_req),
        .int_ack    (int_ack),
        .eoi        (eoi),
        .vec        (vec),
        .vec_valid  (vec_valid),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lowest_set(input logic [26:0] v);
        for (int i = 0; i < 27; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Priority controller: bus A over B over C, lowest channel wins within a bus.
    always_comb begin
        grant_pa   = 1'b0;
        grant_pb   = 1'b0;
        grant_pc   = 1'b0;
        grant_chan = 4'd0;
        if (force_bad) begin
            grant_pa   = 1'b1;
            grant_chan = 4'd12;
        end else if (req_a != 9'd0) begin
            grant_pa   = 1'b1;
            grant_chan = 4'(lowest_set({18'd0, req_a}));
        end else if (req_b != 9'd0) begin
            grant_pb   = 1'b1;
            grant_chan = 4'(lowest_set({18'd0, req_b}));
        end else if (req_c != 9'd0) begin
            grant_pc   = 1'b1;
            grant_chan = 4'(lowest_set({18'd0, req_c}));
        end
    end

    // Reference model: pending set of sources plus the handshake phase.
    localparam int PH_IDLE = 0, PH_WAIT_ACK = 1, PH_VEC = 2, PH_SERVICE = 3;
    logic [26:0] m_pend, m_prev;
    int          m_phase;
    int          m_lat;
    logic        m_int_req, m_err, m_vv;
    logic [7:0]  m_vec;
    logic [7:0]  sb_q[$];
    logic        started = 1'b0;

    always @(posedge clk) begin
        logic [26:0] masked;
        int          clr;
        m_err = 1'b0;
        m_vv  = 1'b0;
        clr   = -1;
        if (rst) begin
            m_pend    = '0;
            m_prev    = '0;
            m_phase   = PH_IDLE;
            m_lat     = 0;
            m_int_req = 1'b0;
            m_vec     = 8'h00;
            started   = 1'b1;
        end else begin
            masked = m_pend & ~irq_mask;
            case (m_phase)
                PH_IDLE: begin
                    if (force_bad) m_err = 1'b1;
                    else if (masked != 27'd0) begin
                        m_lat   = lowest_set(masked);
                        m_phase = PH_WAIT_ACK;
                    end
                end
                PH_WAIT_ACK: begin
                    if (int_ack) begin
                        m_vec   = 8'h20 + 8'(m_lat);
                        m_vv    = 1'b1;
                        sb_q.push_back(m_vec);
                        clr     = m_lat;
                        m_phase = PH_VEC;
                    end
                end
                PH_VEC:  m_phase = PH_SERVICE;
                default: if (eoi) m_phase = PH_IDLE;
            endcase
            if (clr >= 0) m_pend[clr] = 1'b0;
            m_pend    = m_pend | (irq_in & ~m_prev);
            m_prev    = irq_in;
            m_int_req = (m_phase == PH_WAIT_ACK);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare every output against the model and pop the scoreboard on vec_valid.
    always @(posedge clk) begin
        logic [26:0] mm;
        #3;
        if (started) begin
            mm = m_pend & ~irq_mask;
            chk("mon_req_a", {23'd0, req_a}, {23'd0, mm[8:0]});
            chk("mon_req_b", {23'd0, req_b}, {23'd0, mm[17:9]});
            chk("mon_req_c", {23'd0, req_c}, {23'd0, mm[26:18]});
            chk("mon_int_req", {31'd0, int_req}, {31'd0, m_int_req});
            chk("mon_err", {31'd0, err}, {31'd0, m_err});
            chk("mon_vec_valid", {31'd0, vec_valid}, {31'd0, m_vv});
            chk("mon_vec", {24'd0, vec}, {24'd0, m_vec});
            if (vec_valid === 1'b1) begin
                chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) chk("sb_vec", {24'd0, vec}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (int_req !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("int_req_wait", {31'd0, int_req}, 32'd1);
    endtask

    task automatic serve(input logic [7:0] exp_vec);
        wait_req();
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        chk("serve_vec", {24'd0, vec}, {24'd0, exp_vec});
        chk("serve_vv_hi", {31'd0, vec_valid}, 32'd1);
        chk("serve_int_req_lo", {31'd0, int_req}, 32'd0);
        @(negedge clk);
        chk("serve_vv_lo", {31'd0, vec_valid}, 32'd0);
        eoi = 1'b1;
        @(negedge clk);
        eoi = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1; irq_in = '0; irq_mask = '0; int_ack = 1'b0; eoi = 1'b0; force_bad = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_int_req", {31'd0, int_req}, 32'd0);
        chk("rst_vec", {24'd0, vec}, 32'd0);
        chk("rst_vec_valid", {31'd0, vec_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_req_a", {23'd0, req_a}, 32'd0);
        @(negedge clk);

        // Bus B channel 4: two-cycle latency, vector 0x2D.
        irq_in[13] = 1'b1;
        @(negedge clk);
        chk("t1_req_b", {23'd0, req_b}, 32'h010);
        chk("t1_int_req_early", {31'd0, int_req}, 32'd0);
        @(negedge clk);
        chk("t1_int_req", {31'd0, int_req}, 32'd1);
        irq_in[13] = 1'b0;
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        chk("t1_vec", {24'd0, vec}, 32'h2D);
        chk("t1_vv", {31'd0, vec_valid}, 32'd1);
        chk("t1_int_req_lo", {31'd0, int_req}, 32'd0);
        chk("t1_req_b_clr", {23'd0, req_b}, 32'd0);
        @(negedge clk);
        chk("t1_vv_lo", {31'd0, vec_valid}, 32'd0);
        chk("t1_vec_hold", {24'd0, vec}, 32'h2D);
        eoi = 1'b1;
        @(negedge clk);
        eoi = 1'b0;

        // Two simultaneous sources: A/0 first, then C/8.
        irq_in[0] = 1'b1; irq_in[26] = 1'b1;
        repeat (2) @(negedge clk);
        chk("t2_int_req", {31'd0, int_req}, 32'd1);
        serve(8'h20);
        irq_in = '0;
        serve(8'h3A);

        // Masked source stays pending, appears once unmasked.
        irq_mask[5] = 1'b1; irq_in[5] = 1'b1;
        repeat (3) @(negedge clk);
        chk("t3_req_a_masked", {23'd0, req_a}, 32'd0);
        chk("t3_no_int_req", {31'd0, int_req}, 32'd0);
        irq_mask = '0;
        #1;
        chk("t3_req_a_unmasked", {23'd0, req_a}, 32'h020);
        serve(8'h25);
        irq_in = '0;

        // Re-raise of A/2 during its own service is held until after eoi.
        @(negedge clk);
        irq_in[2] = 1'b1;
        wait_req();
        irq_in[2] = 1'b0;
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        chk("t4_vec", {24'd0, vec}, 32'h22);
        irq_in[2] = 1'b1;
        @(negedge clk);
        chk("t4_req_a_reset", {23'd0, req_a}, 32'h004);
        repeat (3) begin
            @(negedge clk);
            chk("t4_no_int_req", {31'd0, int_req}, 32'd0);
        end
        eoi = 1'b1;
        @(negedge clk);
        eoi = 1'b0;
        chk("t4_idle_no_req", {31'd0, int_req}, 32'd0);
        @(negedge clk);
        chk("t4_int_req_after_eoi", {31'd0, int_req}, 32'd1);
        serve(8'h22);
        irq_in = '0;

        // Illegal channel code.
        @(negedge clk);
        force_bad = 1'b1;
        @(negedge clk);
        force_bad = 1'b0;
        chk("t5_err", {31'd0, err}, 32'd1);
        chk("t5_int_req", {31'd0, int_req}, 32'd0);
        @(negedge clk);
        chk("t5_err_lo", {31'd0, err}, 32'd0);

        // Reset in REQ with three sources pending; a later ack is ignored.
        irq_in[1] = 1'b1; irq_in[10] = 1'b1; irq_in[20] = 1'b1;
        wait_req();
        rst = 1'b1; irq_in = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_req_a", {23'd0, req_a}, 32'd0);
        chk("t6_req_b", {23'd0, req_b}, 32'd0);
        chk("t6_req_c", {23'd0, req_c}, 32'd0);
        chk("t6_int_req", {31'd0, int_req}, 32'd0);
        chk("t6_vec", {24'd0, vec}, 32'd0);
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        chk("t6_ack_ignored", {31'd0, vec_valid}, 32'd0);

        // Randomized traffic, checked by the monitor against the model.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            r = $urandom & $urandom & $urandom & $urandom;
            irq_in = irq_in ^ r[26:0];
            if ($urandom_range(0, 49) == 0) begin
                r = $urandom & $urandom;
                irq_mask = r[26:0];
            end
            force_bad = ($urandom_range(0, 39) == 0);
            int_ack   = ($urandom_range(0, 2) == 0);
            eoi       = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        rst = 1'b0; force_bad = 1'b0; int_ack = 1'b0; eoi = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
